// File: rtl/conv_acc_requant_if.sv
// Bus between the dual-lane conv multiplier, conv_acc_requant and the feature-map writer.
// The master drives the product stream and out_rdy; the slave (the accumulator) drives results.
interface conv_acc_requant_if #(
    parameter int SHIFT_W = 5
);
    logic                mult_vld;
    logic                mult_first;
    logic                mult_last;
    logic signed [15:0]  data_ab;
    logic signed [15:0]  data_db;
    logic [SHIFT_W-1:0]  shift;
    logic                out_vld;
    logic                out_rdy;
    logic signed [7:0]   out_ab;
    logic signed [7:0]   out_db;

    modport master (
        output mult_vld, mult_first, mult_last, data_ab, data_db, shift, out_rdy,
        input  out_vld, out_ab, out_db
    );

    modport slave (
        input  mult_vld, mult_first, mult_last, data_ab, data_db, shift, out_rdy,
        output out_vld, out_ab, out_db
    );
endinterface

// File: rtl/conv_acc_requant.sv
// Dual-lane window accumulator with round/shift/saturate requant to int8 and a 2-entry output FIFO.
// Optional macro CONV_RELU_EN clamps negative lane results to 0 after saturation.
module conv_acc_requant #(
    parameter int ACC_W   = 32,
    parameter int SHIFT_W = 5
) (
    input  logic               sclk,
    input  logic               s_rst,
    conv_acc_requant_if.slave  bus,
    output logic               ovf_err,
    output logic               seq_err
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t                    state, state_nxt;
    logic                      eff_first;
    logic                      seq_hit;

    logic signed [ACC_W-1:0]   acc_ab, acc_db;
    logic [SHIFT_W-1:0]        sh1;
    logic                      done1;

    logic signed [ACC_W:0]     r_ab, r_db;
    logic                      v2;

    logic signed [7:0]         sat_ab, sat_db;

    logic                      h_v, t_v;
    logic signed [7:0]         h_ab, h_db, t_ab, t_db;
    logic                      push, pop;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [15:0] p);
        return {{(ACC_W-16){p[15]}}, p};
    endfunction

    function automatic logic signed [ACC_W:0] requant(input logic signed [ACC_W-1:0] a,
                                                      input logic [SHIFT_W-1:0] s);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        ext = {a[ACC_W-1], a};
        rnd = '0;
        if (s != '0)
            rnd[s - 1'b1] = 1'b1;
        return (ext + rnd) >>> s;
    endfunction

    function automatic logic signed [7:0] saturate(input logic signed [ACC_W:0] r);
        logic signed [7:0] res;
        if (r > (ACC_W+1)'(127))
            res = 8'sd127;
        else if (r < (ACC_W+1)'(-128))
            res = -8'sd128;
        else
            res = r[7:0];
`ifdef CONV_RELU_EN
        if (res[7])
            res = '0;
`endif
        return res;
    endfunction

    always_ff @(posedge sclk) begin
        if (s_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A product arriving in IDLE always opens a window, with or without mult_first.
    always_comb begin
        state_nxt = state;
        eff_first = 1'b0;
        seq_hit   = 1'b0;
        if (bus.mult_vld) begin
            eff_first = bus.mult_first || (state == IDLE);
            seq_hit   = (state == IDLE) ? !bus.mult_first : bus.mult_first;
            state_nxt = bus.mult_last ? IDLE : ACC;
        end
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            acc_ab  <= '0;
            acc_db  <= '0;
            sh1     <= '0;
            done1   <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            done1 <= bus.mult_vld && bus.mult_last;
            if (seq_hit)
                seq_err <= 1'b1;
            if (bus.mult_vld) begin
                sh1    <= bus.shift;
                acc_ab <= eff_first ? sext(bus.data_ab) : acc_ab + sext(bus.data_ab);
                acc_db <= eff_first ? sext(bus.data_db) : acc_db + sext(bus.data_db);
            end
        end
    end

    // Shift travels with the closed sum so a following window may use a different one.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_ab <= '0;
            r_db <= '0;
            v2   <= 1'b0;
        end else begin
            v2 <= done1;
            if (done1) begin
                r_ab <= requant(acc_ab, sh1);
                r_db <= requant(acc_db, sh1);
            end
        end
    end

    always_comb begin
        sat_ab = saturate(r_ab);
        sat_db = saturate(r_db);
    end

    assign push = v2;
    assign pop  = h_v && bus.out_rdy;

    // Head register drives the outputs directly; tail only holds the second entry.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            h_v     <= 1'b0;
            t_v     <= 1'b0;
            h_ab    <= '0;
            h_db    <= '0;
            t_ab    <= '0;
            t_db    <= '0;
            ovf_err <= 1'b0;
        end else if (pop) begin
            if (t_v) begin
                h_ab <= t_ab;
                h_db <= t_db;
                t_v  <= push;
                if (push) begin
                    t_ab <= sat_ab;
                    t_db <= sat_db;
                end
            end else if (push) begin
                h_ab <= sat_ab;
                h_db <= sat_db;
            end else begin
                h_v <= 1'b0;
            end
        end else if (push) begin
            if (!h_v) begin
                h_ab <= sat_ab;
                h_db <= sat_db;
                h_v  <= 1'b1;
            end else if (!t_v) begin
                t_ab <= sat_ab;
                t_db <= sat_db;
                t_v  <= 1'b1;
            end else begin
                ovf_err <= 1'b1;
            end
        end
    end

    assign bus.out_vld = h_v;
    assign bus.out_ab  = h_ab;
    assign bus.out_db  = h_db;

endmodule

// File: tb/tb_conv_acc_requant.sv
// Scoreboard bench for conv_acc_requant: stimulus pushes expected int8 pairs, a monitor pops on out_vld&out_rdy.
// Expected values are hand-computed; CONV_RELU_EN selects the clamped variants.
module tb_conv_acc_requant;

    logic sclk = 1'b0;
    logic s_rst;
    logic ovf_err, seq_err;

    conv_acc_requant_if #(.SHIFT_W(5)) bus ();

    conv_acc_requant #(.ACC_W(32), .SHIFT_W(5)) dut (
        .sclk    (sclk),
        .s_rst   (s_rst),
        .bus     (bus),
        .ovf_err (ovf_err),
        .seq_err (seq_err)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic signed [7:0] ab;
        logic signed [7:0] db;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic toggle_en = 1'b0;

    function automatic logic signed [7:0] rl(input int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 8'sd0 : 8'(v);
`else
        return 8'(v);
`endif
    endfunction

    function automatic res_t mk(input int ab, input int db);
        res_t r;
        r.ab = rl(ab);
        r.db = rl(db);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the oldest expected result.
    always @(negedge sclk) begin
        if (!s_rst && bus.out_vld && bus.out_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got ab=%0d db=%0d expected none", bus.out_ab, bus.out_db);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("out_ab", int'(bus.out_ab), int'(e.ab));
                check("out_db", int'(bus.out_db), int'(e.db));
            end
        end
    end

    task automatic drive(input logic v, input logic f, input logic l,
                         input int ab, input int db, input int sh);
        bus.mult_vld   = v;
        bus.mult_first = f;
        bus.mult_last  = l;
        bus.data_ab    = 16'(ab);
        bus.data_db    = 16'(db);
        bus.shift      = 5'(sh);
        if (toggle_en)
            bus.out_rdy = !bus.out_rdy;
        @(posedge sclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mult_vld   = 1'b0;
        bus.mult_first = 1'b0;
        bus.mult_last  = 1'b0;
        bus.data_ab    = '0;
        bus.data_db    = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic window(input int n, input int ab, input int db, input int sh);
        for (int i = 0; i < n; i++)
            drive(1'b1, i == 0, i == n - 1, ab, db, sh);
        idle_inputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++)
            idle(1);
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        idle(2);
        s_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        bus.shift   = '0;
        bus.out_rdy = 1'b1;
        s_rst       = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        s_rst = 1'b0;
        @(negedge sclk);
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_out_ab", int'(bus.out_ab), 0);
        check("rst_out_db", int'(bus.out_db), 0);
        check("rst_ovf_err", ovf_err, 0);
        check("rst_seq_err", seq_err, 0);
        @(posedge sclk);
        #1;

        // 9x100 -> 900 -> (900+8)>>>4 = 56; 9x-50 -> -450 -> (-442)>>>4 = -28
        exp_q.push_back(mk(56, -28));
        window(9, 100, -50, 4);
        @(negedge sclk);
        check("lat_t1_vld", bus.out_vld, 0);
        @(posedge sclk);
        @(negedge sclk);
        check("lat_t2_vld", bus.out_vld, 0);
        @(posedge sclk);
        @(negedge sclk);
        check("lat_t3_vld", bus.out_vld, 1);
        @(posedge sclk);
        @(negedge sclk);
        check("lat_pulse_end", bus.out_vld, 0);
        @(posedge sclk);
        #1;

        // single-product window, shift 0: -7 passes, 300 saturates
        exp_q.push_back(mk(-7, 127));
        window(1, -7, 300, 0);
        drain();

        // 9000 -> (9002)>>>2 = 2250 -> 127; -9000 -> (-8998)>>>2 = -2250 -> -128
        exp_q.push_back(mk(127, 0));
        window(9, 1000, 0, 2);
        exp_q.push_back(mk(-128, 0));
        window(9, -1000, 0, 2);
        drain();

        // FIFO full: third result is dropped
        bus.out_rdy = 1'b0;
        exp_q.push_back(mk(1, 0));
        exp_q.push_back(mk(2, 0));
        window(1, 1, 0, 0);
        window(1, 2, 0, 0);
        window(1, 3, 0, 0);
        idle(5);
        check("ovf_err_set", ovf_err, 1);
        check("ovf_head_vld", bus.out_vld, 1);
        bus.out_rdy = 1'b1;
        drain();
        idle(3);
        check("ovf_no_third", bus.out_vld, 0);

        // protocol error: window opened without first
        do_reset();
        check("rst2_ovf_err", ovf_err, 0);
        check("rst2_seq_err", seq_err, 0);
        exp_q.push_back(mk(10, 0));
        drive(1'b1, 1'b0, 1'b0, 5, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 5, 0, 0);
        idle_inputs();
        drain();
        check("seq_err_set", seq_err, 1);

        // mid-window reset discards everything
        drive(1'b1, 1'b1, 1'b0, 9, 9, 0);
        drive(1'b1, 1'b0, 1'b0, 9, 9, 0);
        do_reset();
        idle(6);
        check("midrst_out_vld", bus.out_vld, 0);
        check("midrst_ovf_err", ovf_err, 0);
        check("midrst_seq_err", seq_err, 0);

        // back-to-back 2-product windows with out_rdy toggling each cycle
        toggle_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(mk(2 * k + 1, -2 * k));
            drive(1'b1, 1'b1, 1'b0, k, -k, 0);
            drive(1'b1, 1'b0, 1'b1, k + 1, -k, 0);
        end
        idle_inputs();
        drain();
        toggle_en   = 1'b0;
        bus.out_rdy = 1'b1;
        idle(2);
        check("b2b_ovf_err", ovf_err, 0);
        check("b2b_seq_err", seq_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
